nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around one instance of the team's 4-bit carry-lookahead adder (lookAheadAdder4).
- Upstream: the block captures operands through a valid/ready handshake and feeds one 4-bit slice per clock into the lookahead adder, least-significant nibble first.
- Downstream: the block registers each nibble sum and carry-out, chains the carry, and presents the assembled result through a second valid/ready handshake.

---
 rtl/nibble_serial_adder.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead adder processes a nibble per clock, LSB first.
// Optional signed-overflow output is enabled with `define NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [3:0]       nib_sum_s;
  logic             nib_cout_s;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_r;
`endif

  assign a_nib_s = a_r[{idx_r, 2'b00} +: 4];
  assign b_nib_s = b_r[{idx_r, 2'b00} +: 4];

  lookAheadAdder4 u_cla (
    .a    (a_nib_s),
    .b    (b_nib_s),
    .cin  (carry_r),
    .sum  (nib_sum_s),
    .cout (nib_cout_s)
  );

  // Control FSM, operand capture and nibble-by-nibble result assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= '0;
            state_r <= ADD;
          end
        end
        ADD: begin
          sum_r[{idx_r, 2'b00} +: 4] <= nib_sum_s;
          carry_r <= nib_cout_s;
          if (idx_r == LAST_IDX) begin
            cout_r  <= nib_cout_s;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            // nib_sum_s[3] is the final result MSB written on this edge
            ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (nib_sum_s[3] != a_r[WIDTH-1]);
`endif
            idx_r   <= '0;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + IDXW'(1'b1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == ADD);
  assign sum       = sum_r;
  assign cout      = cout_r;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  assign ovf       = ovf_r;
`endif

endmodule

// Team 4-bit carry-lookahead adder; all carries computed directly from generate/propagate.
module lookAheadAdder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [4:0] c_s;

  assign p_s    = a ^ b;
  assign g_s    = a & b;
  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
  assign sum    = p_s ^ c_s[3:0];
  assign cout   = c_s[4];

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16, 40 ns clock): directed vectors with
// hand-computed results, a monitor checking each output handshake, plus timing/reset checks.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each completed output handshake against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum", {16'd0, sum}, {16'd0, e.sum});
        check("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  task automatic accept(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", 32'd0, 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                      input int hold, input bit chk_carry);
    exp_t e;
    accept(va, vb, vc);
    e.sum = es; e.cout = ec; e.ovf = eo;
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    a = 16'h0BAD; b = 16'h0BAD; cin = 1'b1;
    check("busy_first", {31'd0, busy}, 32'd1);
    check("in_ready_add", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i < NIB; i++) begin
      @(posedge clk); #1;
      check("busy", {31'd0, busy}, 32'd1);
      check("out_valid_early", {31'd0, out_valid}, 32'd0);
      if (chk_carry) check("carry_reg", {31'd0, dut.carry_r}, 32'd1);
    end
    @(posedge clk); #1;
    check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {16'd0, sum}, {16'd0, es});
      check("hold_cout", {31'd0, cout}, {31'd0, ec});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_clear", {31'd0, out_valid}, 32'd0);
    check("in_ready_return", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int guard;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #5;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    send(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 5, 1'b1);
    // Result 0x5555 leaves nonzero sum bits for the abort check below
    send(16'h2222, 16'h3333, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);

    // Abort mid-ADD: reset in the second ADD cycle
    accept(16'h1111, 16'h2222, 1'b0);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #5;
    reset = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    #5;
    reset = 1'b0;
    for (int i = 0; i < NIB + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
    send(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
`endif

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
